// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider: FSM state codes,
// start/ready level names and the common zero word.
// Optional early-out feature is controlled by DIV_EARLY_OUT_EN (see div.sv).
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/div.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; result = {remainder, quotient}.
// Latency: WIDTH+1 edges from start sampled in FREE to ready (2 edges for divide-by-zero).
// Handshake: start held until ready consumed; annul aborts at any time. Macro DIV_EARLY_OUT_EN
// enables a 1-edge finish when |a| < |b|.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO      = WIDTH'(ZERO_WORD);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifts out the top, quotient fills the bottom
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // Operand magnitudes: only negate when the signed op sees a set MSB.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (signed_div && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign abs_b = (signed_div && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // One restoring step: shift {rem, dividend} left, trial-subtract the divisor.
  // The shifted remainder needs one extra bit since it can reach 2*divisor-1.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] rem_fix, quo_fix;
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, dvs_q});
  assign diff    = rem_sh[WIDTH-1:0] - dvs_q;  // exact whenever ge, as the difference < divisor
  assign rem_nxt = ge ? diff : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ge};

  // Sign fix-up applied to the final step's values on the way into END.
  assign quo_fix = (sgn_q && (sign_a_q != sign_b_q)) ? -quo_nxt : quo_nxt;
  assign rem_fix = (sgn_q && sign_a_q) ? -rem_nxt : rem_nxt;

  // State and datapath registers, all cleared by the async reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state, datapath and registered-output logic; annul overrides every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ready_d  = ready_q;

    if (annul) begin
      state_d  = DIV_FREE;
      result_d = '0;
      ready_d  = DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          if (start == DIV_START) begin
            if (operand_b == ZERO) begin
              state_d = DIV_BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              // Quotient is zero and the remainder is the untouched signed dividend.
              state_d  = DIV_END;
              result_d = {operand_a, ZERO};
              ready_d  = DIV_RESULT_READY;
`endif
            end else begin
              state_d  = DIV_ON;
              quo_d    = abs_a;
              dvs_d    = abs_b;
              rem_d    = '0;
              cnt_d    = '0;
              sign_a_d = operand_a[WIDTH-1];
              sign_b_d = operand_b[WIDTH-1];
              sgn_d    = signed_div;
            end
          end
        end

        DIV_BY_ZERO: begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end

        DIV_ON: begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = DIV_END;
            result_d = {rem_fix, quo_fix};
            ready_d  = DIV_RESULT_READY;
          end
        end

        DIV_END: begin
          // Hold the result until EX drops start for a cycle.
          if (start == DIV_STOP) begin
            state_d  = DIV_FREE;
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU, instantiated beside the EX stage.
- EX raises its stall request to the pipeline stall controller while a division is in flight. That request produces stall vector 001111.
- EX consumes the 64-bit result as {HI=remainder, LO=quotient}.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH bits; the iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in FREE
- operand_a  in  WIDTH  dividend; sampled with start in FREE
- operand_b  in  WIDTH  divisor; sampled with start in FREE
- start  in  1  held high by EX from issue until it has consumed ready
- annul  in  1  abort (branch-delay flush / exception); overrides everything
- result  out  2*WIDTH  {remainder, quotient}; valid only while ready=1
- ready  out  1  result valid; registered

Behaviour:
- Reset (reset=0, async): state=FREE, result=0, ready=0, counter=0, internal registers cleared. Outputs are all registered.
- States: FREE, BY_ZERO, ON, END (2-bit encoding).
- FREE:
  - If start=1 and annul=0 and operand_b=0: go to BY_ZERO.
  - If start=1 and annul=0 and operand_b!=0: go to ON. Latch |a| and |b|, taking the magnitude only when signed_div=1 and the MSB is set. Latch both sign bits. Counter=0, partial remainder=0.
  - Otherwise stay in FREE with ready=0 and result=0.
- BY_ZERO: next edge goes to END with result=0.
- ON:
  - One restoring step per clock. Shift {rem, dividend} left by 1, then trial-subtract the divisor from rem.
  - If the difference is non-negative, rem = difference and the quotient LSB = 1; else the quotient LSB = 0.
  - Counter increments each step. On the step where counter reaches WIDTH, go to END.
  - Sign fix-up is applied when entering END:
    - quotient is negated if signed_div and sign_a != sign_b;
    - remainder is negated if signed_div and sign_a=1.
  - Latency: start seen in FREE at edge 0, ready=1 after edge WIDTH+1 (33 edges for WIDTH=32).
- END:
  - ready=1 and result is held stable.
  - If start=1: stay in END.
  - If start=0: next edge goes to FREE with ready=0 and result=0.
  - A fresh division therefore needs start low for at least one cycle.
- annul=1 in any state: next edge goes to FREE with ready=0 and result=0. Annul wins over a simultaneous start.
- start dropped mid-ON without annul: the division runs to END, then returns to FREE on the following edge. No hang.
- Operand changes during ON/BY_ZERO/END are ignored; operands are only sampled in FREE.
- Overflow case 0x80000000 / 0xFFFFFFFF, signed: quotient wraps to 0x80000000, remainder 0. No trap is raised.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, if the magnitudes satisfy |a| < |b| with b != 0, go straight to END. result = {operand_a, 0}, i.e. remainder is the original signed dividend and quotient is 0. Latency is 1 edge.
- Undefined: all nonzero-divisor operations take the full WIDTH+1 edges.
- Results must be bit-identical either way.

Decomposition:
- The shared defines file gains:
  - state codes DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END;
  - DIV_START / DIV_STOP and DIV_RESULT_READY / DIV_RESULT_NOT_READY;
  - the existing ZERO_WORD constant is reused.
- No sub-module. Magnitude and negate logic is a few lines inline, and the datapath and FSM are tightly coupled.

Test Plan:
- DIVU 100 / 7, start held: ready rises exactly 33 edges after start is sampled; result = {32'd2, 32'd14}. Drop start: ready=0 and result=0 on the next edge.
- DIV -7 / 2, i.e. 0xFFFFFFF9 / 0x2: result = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / -2: result = {0x1, 0xFFFFFFFD}.
- Divide by zero, 5 / 0: BY_ZERO, then END; ready=1 at edge 2 with result=0. Signed overflow 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
- annul pulsed at iteration 10: FREE on the next edge, ready never asserts. A new start two cycles later with 9 / 3 yields {0, 3}.
- Assert reset low mid-ON: ready=0, result=0, state FREE asynchronously. Release reset, run 0xFFFFFFFF / 1 unsigned: result {0, 0xFFFFFFFF}.
- With DIV_EARLY_OUT_EN, 3 / 10: ready after 1 edge, result {3, 0}. Without the macro the same result arrives after 33 edges.
